// File: rtl/serial_shift_tx_pkg.sv
// ---------------------------------------------------------------------------
// serial_shift_tx_pkg
//   Shared definitions for the display-link serial transmitter family:
//   FSM state encodings and the legal parameter ranges.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package serial_shift_tx_pkg;

  // 2'b11 is not a legal state; the transmitter decodes it as idle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_LATCH = 2'b10
  } tx_state_e;

  localparam int unsigned WIDTH_MIN   = 2;
  localparam int unsigned WIDTH_MAX   = 16;
  localparam int unsigned CLK_DIV_MIN = 1;
  localparam int unsigned CLK_DIV_MAX = 255;

  // True only for the two transfer states; anything else counts as idle.
  function automatic logic is_active(input tx_state_e s);
    return (s == ST_SHIFT) || (s == ST_LATCH);
  endfunction

endpackage

// File: rtl/serial_shift_tx_prescaler.sv
// ---------------------------------------------------------------------------
// ls_phase_prescaler
//   Phase counter that produces a one-cycle strobe every CLK_DIV enabled
//   cycles. The counter is held at zero while disabled, so the first strobe
//   after enable rises comes exactly CLK_DIV cycles later.
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   enable    - count while high, clear while low
//   half_tick - high in the last cycle of each CLK_DIV-cycle period
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ls_phase_prescaler #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic half_tick
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] phase_q, phase_d;

  always_comb begin
    half_tick = enable && (phase_q == LAST);
    phase_d   = '0;
    if (enable && !half_tick) begin
      phase_d = phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/serial_shift_tx.sv
// ---------------------------------------------------------------------------
// serial_shift_tx
//   Parallel-in, serial-out transmitter for the clock display link. A word
//   accepted over load_valid/load_ready is shifted out MSB-first on sdata
//   with a generated sclk, then rclk is pulsed so a 74LS164/595-style
//   receiver latches it.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   data_in    - word to transmit, sampled on acceptance
//   load_valid - data_in is valid
//   load_ready - high only while idle (and out of reset)
//   sdata      - serial data, MSB first, changes only on sclk falling side
//   sclk       - shift clock, receiver samples on its rising edge
//   rclk       - latch strobe, CLK_DIV cycles after the last bit
//   busy       - high while a transfer is in progress
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module serial_shift_tx
  import serial_shift_tx_pkg::*;
#(
  parameter int unsigned DELAY   = 10,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdata,
  output logic             sclk,
  output logic             rclk,
  output logic             busy
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_shift_tx: WIDTH out of range");
  end
  if (CLK_DIV < CLK_DIV_MIN || CLK_DIV > CLK_DIV_MAX) begin : g_bad_div
    $error("serial_shift_tx: CLK_DIV out of range");
  end

  localparam int unsigned BW = $clog2(WIDTH);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             sdata_q, sdata_d;
  logic             sclk_q, sclk_d;
  logic             rclk_q, rclk_d;
  logic             active;
  logic             half_tick;

  assign active = is_active(state_q);

  ls_phase_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (active),
    .half_tick(half_tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sdata_d   = sdata_q;
    sclk_d    = sclk_q;
    rclk_d    = rclk_q;

    case (state_q)
      ST_SHIFT: begin
        if (half_tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // End of the high half: advance to the next bit. sdata is
            // registered here so it is presented a full half-period ahead
            // of the next sclk rising edge.
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            if (bit_cnt_q == '0) begin
              state_d = ST_LATCH;
              sdata_d = 1'b0;
              rclk_d  = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q - BW'(1);
              sdata_d   = shreg_q[WIDTH-2];
            end
          end
        end
      end

      ST_LATCH: begin
        if (half_tick) begin
          state_d = ST_IDLE;
          rclk_d  = 1'b0;
        end
      end

      default: begin
        // Idle, including the unused encoding.
        state_d = ST_IDLE;
        sdata_d = 1'b0;
        sclk_d  = 1'b0;
        rclk_d  = 1'b0;
        if (load_valid) begin
          state_d   = ST_SHIFT;
          shreg_d   = data_in;
          bit_cnt_d = BW'(WIDTH - 1);
          sdata_d   = data_in[WIDTH-1];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sdata_q   <= 1'b0;
      sclk_q    <= 1'b0;
      rclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sdata_q   <= sdata_d;
      sclk_q    <= sclk_d;
      rclk_q    <= rclk_d;
    end
  end

  // load_ready is forced low while reset is asserted so no word can be
  // offered into a transmitter that is being held in reset.
  assign #(DELAY) sdata      = sdata_q;
  assign #(DELAY) sclk       = sclk_q;
  assign #(DELAY) rclk       = rclk_q;
  assign #(DELAY) busy       = active;
  assign #(DELAY) load_ready = rst_n & ~active;

endmodule

// File: tb/tb_serial_shift_tx.sv
`timescale 1ns/1ps
module tb_serial_shift_tx;

  localparam int unsigned W0 = 8, D0 = 2;
  localparam int unsigned W1 = 4, D1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rstn, lv, rdy, sd, sc, rc, bsy;
  logic [7:0] din0;
  logic [3:0] din1;

  serial_shift_tx #(.DELAY(1), .WIDTH(W0), .CLK_DIV(D0)) u_dut0 (
    .clk(clk), .rst_n(rstn[0]), .data_in(din0), .load_valid(lv[0]),
    .load_ready(rdy[0]), .sdata(sd[0]), .sclk(sc[0]), .rclk(rc[0]), .busy(bsy[0])
  );

  serial_shift_tx #(.DELAY(1), .WIDTH(W1), .CLK_DIV(D1)) u_dut1 (
    .clk(clk), .rst_n(rstn[1]), .data_in(din1), .load_valid(lv[1]),
    .load_ready(rdy[1]), .sdata(sd[1]), .sclk(sc[1]), .rclk(rc[1]), .busy(bsy[1])
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: words pushed when offered, popped when the receiver latches.
  logic [15:0] sbq0[$];
  logic [15:0] sbq1[$];

  // Receiver model (74LS595-like) plus link timing monitors.
  int unsigned div_of [2] = '{D0, D1};
  logic [15:0] mask_of [2] = '{16'h00FF, 16'h000F};
  logic [15:0] rxsh [2] = '{16'h0, 16'h0};
  logic [15:0] rxlat [2] = '{16'h0, 16'h0};
  int unsigned npulse [2] = '{0, 0};
  int unsigned nlatch [2] = '{0, 0};
  int unsigned schi [2] = '{0, 0};
  int unsigned sclk_bad [2] = '{0, 0};
  int unsigned setup_bad [2] = '{0, 0};
  int unsigned rclen [2] = '{0, 0};
  int unsigned last_rclen [2] = '{0, 0};
  int unsigned rdylow [2] = '{0, 0};
  int unsigned last_rdylow [2] = '{0, 0};
  logic [1:0] psc = '0, prc = '0, psd = '0, prdy = '1;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rstn[k]) begin
        schi[k] = 0; rclen[k] = 0; rdylow[k] = 0;
      end else begin
        if (sc[k] && !psc[k]) begin
          rxsh[k] = {rxsh[k][14:0], sd[k]};
          npulse[k]++;
          if (sd[k] !== psd[k]) setup_bad[k]++;
        end
        if (sc[k]) schi[k]++;
        else if (psc[k]) begin
          if (schi[k] != div_of[k]) sclk_bad[k]++;
          schi[k] = 0;
        end
        if (rc[k] && !prc[k]) begin
          logic [31:0] exp;
          nlatch[k]++;
          rxlat[k] = rxsh[k] & mask_of[k];
          exp = 32'hBAD0_0000;
          if (k == 0) begin
            if (sbq0.size() > 0) exp = {16'h0, sbq0.pop_front()};
            check("latch0", {16'h0, rxlat[k]}, exp);
          end else begin
            if (sbq1.size() > 0) exp = {16'h0, sbq1.pop_front()};
            check("latch1", {16'h0, rxlat[k]}, exp);
          end
        end
        if (rc[k]) rclen[k]++;
        else if (prc[k]) begin
          last_rclen[k] = rclen[k];
          rclen[k] = 0;
        end
        if (!rdy[k]) rdylow[k]++;
        else if (!prdy[k] && rdylow[k] > 0) begin
          last_rdylow[k] = rdylow[k];
          rdylow[k] = 0;
        end
      end
      psc[k] = sc[k]; prc[k] = rc[k]; psd[k] = sd[k]; prdy[k] = rdy[k];
    end
  end

  // Accept detection at the active edge (outputs still hold pre-edge values).
  int unsigned cyc = 0;
  int unsigned accepts [2] = '{0, 0};
  int unsigned acc_cyc [2] = '{0, 0};
  int unsigned prev_acc [2] = '{0, 0};
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rdy[k] === 1'b1 && lv[k] === 1'b1) begin
        accepts[k]++;
        prev_acc[k] = acc_cyc[k];
        acc_cyc[k] = cyc;
      end
    end
  end

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int k, input int unsigned maxc);
    for (int unsigned i = 0; i < maxc && rdy[k] !== 1'b1; i++) nstep();
    check($sformatf("ready_timeout%0d", k), {31'h0, rdy[k]}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b_pulse, b_latch, b_acc;
    logic [7:0] vec;

    rstn = '0; lv = '0; din0 = '0; din1 = '0;
    // Reset held for three cycles: everything low.
    nstep(); nstep(); nstep();
    check("reset_out0", {27'h0, sd[0], sc[0], rc[0], bsy[0], rdy[0]}, 32'h0);
    check("reset_out1", {27'h0, sd[1], sc[1], rc[1], bsy[1], rdy[1]}, 32'h0);
    rstn = '1;
    nstep();
    check("idle_ready0", {30'h0, rdy[0], bsy[0]}, 32'h2);
    check("idle_ready1", {30'h0, rdy[1], bsy[1]}, 32'h2);

    // Word 8'hA5.
    b_pulse = npulse[0]; b_latch = nlatch[0];
    din0 = 8'hA5; lv[0] = 1'b1; sbq0.push_back(16'h00A5);
    nstep();
    lv[0] = 1'b0;
    check("a5_first_bit", {29'h0, sd[0], sc[0], bsy[0]}, 32'h5);
    check("a5_ready_low", {31'h0, rdy[0]}, 32'h0);
    wait_ready(0, 100);
    check("a5_ready_low_len", last_rdylow[0], 34);
    check("a5_pulses", npulse[0] - b_pulse, 8);
    check("a5_rclk_len", last_rclen[0], 2);
    check("a5_latches", nlatch[0] - b_latch, 1);

    // Back-to-back with load_valid held high.
    b_acc = accepts[0]; b_latch = nlatch[0];
    din0 = 8'h3C; lv[0] = 1'b1;
    sbq0.push_back(16'h003C); sbq0.push_back(16'h00C3);
    for (int i = 0; i < 10 && accepts[0] == b_acc; i++) nstep();
    din0 = 8'hC3;
    for (int i = 0; i < 100 && accepts[0] < b_acc + 2; i++) nstep();
    lv[0] = 1'b0;
    check("b2b_accepts", accepts[0] - b_acc, 2);
    check("b2b_spacing", acc_cyc[0] - prev_acc[0], 35);
    wait_ready(0, 100);
    check("b2b_latches", nlatch[0] - b_latch, 2);

    // load_valid while busy is ignored.
    b_acc = accepts[0]; b_latch = nlatch[0];
    din0 = 8'h01; lv[0] = 1'b1; sbq0.push_back(16'h0001);
    nstep();
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) nstep();
    din0 = 8'hFF; lv[0] = 1'b1;
    nstep();
    lv[0] = 1'b0;
    wait_ready(0, 100);
    for (int i = 0; i < 40; i++) nstep();
    check("busy_ignore_acc", accepts[0] - b_acc, 1);
    check("busy_ignore_lat", nlatch[0] - b_latch, 1);
    check("busy_ignore_idle", {31'h0, bsy[0]}, 32'h0);

    // Reset in the middle of 8'hF0: abort, no latch.
    b_pulse = npulse[0]; b_latch = nlatch[0];
    din0 = 8'hF0; lv[0] = 1'b1;
    nstep();
    lv[0] = 1'b0;
    for (int i = 0; i < 100 && npulse[0] < b_pulse + 4; i++) nstep();
    check("rst_mid_pulses", npulse[0] - b_pulse, 4);
    rstn[0] = 1'b0;
    #2;
    check("rst_mid_out", {27'h0, sd[0], sc[0], rc[0], bsy[0], rdy[0]}, 32'h0);
    nstep(); nstep();
    rstn[0] = 1'b1;
    for (int i = 0; i < 40; i++) nstep();
    check("rst_mid_nolatch", nlatch[0] - b_latch, 0);
    check("rst_mid_held", {16'h0, rxlat[0]}, 32'h01);
    check("rst_mid_idle", {30'h0, rdy[0], bsy[0]}, 32'h2);
    check("dut0_sclk_high", sclk_bad[0], 0);
    check("dut0_setup", setup_bad[0], 0);
    check("dut0_sb_empty", sbq0.size(), 0);

    // WIDTH=4, CLK_DIV=1, word 4'h9.
    b_pulse = npulse[1]; b_latch = nlatch[1];
    din1 = 4'h9; lv[1] = 1'b1; sbq1.push_back(16'h0009);
    vec = '0;
    for (int i = 0; i < 8; i++) begin
      nstep();
      lv[1] = 1'b0;
      vec = {vec[6:0], sc[1]};
    end
    check("d1_sclk_toggle", {24'h0, vec}, 32'h55);
    wait_ready(1, 40);
    check("d1_ready_low_len", last_rdylow[1], 9);
    check("d1_rclk_len", last_rclen[1], 1);
    check("d1_pulses", npulse[1] - b_pulse, 4);
    check("d1_latches", nlatch[1] - b_latch, 1);
    check("d1_sclk_high", sclk_bad[1], 0);
    check("d1_setup", setup_bad[1], 0);
    check("d1_sb_empty", sbq1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
